// File: rtl/fd_pkg.sv
// Shared types and constants for the fetch/decode pipeline register.
// The FD register and the skid buffer both store an fd_entry.
package fd_pkg;

  localparam int          FD_WIDTH  = 16;
  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam logic [4:0]  HALT_OPC  = 5'b00000;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fdState_t;

  typedef struct packed {
    logic [FD_WIDTH-1:0] instr;
    logic [FD_WIDTH-1:0] pcPlus2;
    logic                err;
  } fd_entry;

  // The opcode occupies the top five bits of the instruction word.
  function automatic logic isHalt(input logic [FD_WIDTH-1:0] instr,
                                  input logic [4:0]          opc);
    return instr[FD_WIDTH-1 -: 5] == opc;
  endfunction

endpackage

// File: rtl/fd_skid_buffer.sv
// One-entry holding register for an instruction fetched while decode is stalled.
// Clear wins over load so a flush always leaves the buffer empty.
module fd_skid_buffer
  import fd_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    load,
  input  logic    clear,
  input  fd_entry dataIn,
  output fd_entry dataOut,
  output logic    full
);

  fd_entry entryReg;
  logic    fullReg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entryReg <= '0;
      fullReg  <= 1'b0;
    end else if (clear) begin
      fullReg  <= 1'b0;
    end else if (load) begin
      entryReg <= dataIn;
      fullReg  <= 1'b1;
    end
  end

  assign dataOut = entryReg;
  assign full    = fullReg;

endmodule

// File: rtl/fetch_decode_reg.sv
// F/D pipeline register with stall hold, flush bubble, one-entry skid buffer,
// HALT tracking and a saturating decode-stall counter.
module fetch_decode_reg
  import fd_pkg::*;
#(
  parameter int               WIDTH     = FD_WIDTH,
  parameter logic [WIDTH-1:0] NOP_INSTR = fd_pkg::NOP_INSTR,
  parameter logic [4:0]       HALT_OPC  = fd_pkg::HALT_OPC,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] F_instr,
  input  logic [WIDTH-1:0] F_pcPlus2,
  input  logic             F_valid,
  input  logic             F_err,
  input  logic             stall_D,
  input  logic             flush_D,
  output logic [WIDTH-1:0] FD_instr,
  output logic [WIDTH-1:0] FD_pcPlus2,
  output logic             FD_valid,
  output logic             FD_err,
  output logic             FD_halted,
  output logic             fetch_hold,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam fd_entry BUBBLE = '{instr: NOP_INSTR, pcPlus2: '0, err: 1'b0};

  fdState_t         state;
  fdState_t         stateNext;
  fd_entry          fdReg;
  fd_entry          fdNext;
  fd_entry          fEntry;
  fd_entry          skidOut;
  logic             fdValid;
  logic             fdValidNext;
  logic             skidFull;
  logic             skidLoad;
  logic             skidClear;
  logic [CNT_W-1:0] stallCnt;

  assign fEntry = '{instr: F_instr, pcPlus2: F_pcPlus2, err: F_err};

  fd_skid_buffer uSkid (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (skidLoad),
    .clear  (skidClear),
    .dataIn (fEntry),
    .dataOut(skidOut),
    .full   (skidFull)
  );

  // Priority per edge: flush, then halted hold, then stall hold, then load.
  always_comb begin
    fdNext      = fdReg;
    fdValidNext = fdValid;
    stateNext   = state;
    skidLoad    = 1'b0;
    skidClear   = 1'b0;
    if (flush_D) begin
      fdNext      = BUBBLE;
      fdValidNext = 1'b0;
      stateNext   = RUN;
      skidClear   = 1'b1;
    end else if (state == HALTED) begin
      fdNext = fdReg;
    end else if (stall_D) begin
      skidLoad = F_valid & ~skidFull;
    end else begin
      if (skidFull) begin
        fdNext      = skidOut;
        fdValidNext = 1'b1;
        skidClear   = 1'b1;
      end else if (F_valid) begin
        fdNext      = fEntry;
        fdValidNext = 1'b1;
      end else begin
        fdNext      = BUBBLE;
        fdValidNext = 1'b0;
      end
      // A HALT halts even when it carries a fetch error.
      if (fdValidNext && isHalt(fdNext.instr, HALT_OPC)) begin
        stateNext = HALTED;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fdReg   <= BUBBLE;
      fdValid <= 1'b0;
      state   <= RUN;
    end else begin
      fdReg   <= fdNext;
      fdValid <= fdValidNext;
      state   <= stateNext;
    end
  end

  // Counts cycles where a real instruction sits stalled in decode; never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt <= '0;
    end else if (stall_D && fdValid && !flush_D && (stallCnt != '1)) begin
      stallCnt <= stallCnt + 1'b1;
    end
  end

  assign FD_instr   = fdReg.instr;
  assign FD_pcPlus2 = fdReg.pcPlus2;
  assign FD_err     = fdReg.err;
  assign FD_valid   = fdValid;
  assign FD_halted  = (state == HALTED);
  assign fetch_hold = skidFull | (state == HALTED);
  assign stall_cnt  = stallCnt;

endmodule

// File: tb/tb_fetch_decode_reg.sv
// Self-checking bench: a queue-based reference model checked every cycle,
// plus hand-computed literal expectations for each directed scenario.
module tb_fetch_decode_reg;

  localparam int CNT_MAX = 15;

  logic        clk;
  logic        rst_n;
  logic [15:0] F_instr;
  logic [15:0] F_pcPlus2;
  logic        F_valid;
  logic        F_err;
  logic        stall_D;
  logic        flush_D;
  logic [15:0] FD_instr;
  logic [15:0] FD_pcPlus2;
  logic        FD_valid;
  logic        FD_err;
  logic        FD_halted;
  logic        fetch_hold;
  logic [3:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  fetch_decode_reg #(.CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .F_instr   (F_instr),
    .F_pcPlus2 (F_pcPlus2),
    .F_valid   (F_valid),
    .F_err     (F_err),
    .stall_D   (stall_D),
    .flush_D   (flush_D),
    .FD_instr  (FD_instr),
    .FD_pcPlus2(FD_pcPlus2),
    .FD_valid  (FD_valid),
    .FD_err    (FD_err),
    .FD_halted (FD_halted),
    .fetch_hold(fetch_hold),
    .stall_cnt (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state: FD contents, halted flag, skid as a queue, counter.
  logic [15:0] mInstr = 16'h0800;
  logic [15:0] mPc    = 16'h0000;
  logic        mValid = 1'b0;
  logic        mErr   = 1'b0;
  logic        mHalted = 1'b0;
  logic [32:0] skidQ[$];
  logic [32:0] skidHead;
  int          mCnt = 0;
  bit          countIt;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic fv, input logic [15:0] instr,
                               input logic [15:0] pc, input logic e,
                               input logic s, input logic f);
    F_valid   = fv;
    F_instr   = instr;
    F_pcPlus2 = pc;
    F_err     = e;
    stall_D   = s;
    flush_D   = f;
    @(negedge clk);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mInstr  = 16'h0800;
      mPc     = 16'h0000;
      mValid  = 1'b0;
      mErr    = 1'b0;
      mHalted = 1'b0;
      mCnt    = 0;
      skidQ.delete();
    end else begin
      countIt = stall_D && mValid && !flush_D;
      if (flush_D) begin
        mInstr  = 16'h0800;
        mPc     = 16'h0000;
        mValid  = 1'b0;
        mErr    = 1'b0;
        mHalted = 1'b0;
        skidQ.delete();
      end else if (mHalted) begin
        mValid = mValid;
      end else if (stall_D) begin
        if (F_valid) begin
          if (skidQ.size() == 0) begin
            skidQ.push_back({F_instr, F_pcPlus2, F_err});
          end else begin
            checks++;
            errors++;
            $display("[TB] FAIL protocol F_valid while skid full actual=1 expected=0 at %0t", $time);
          end
        end
      end else begin
        if (skidQ.size() > 0) begin
          skidHead = skidQ.pop_front();
          {mInstr, mPc, mErr} = skidHead;
          mValid = 1'b1;
        end else if (F_valid) begin
          {mInstr, mPc, mErr} = {F_instr, F_pcPlus2, F_err};
          mValid = 1'b1;
        end else begin
          mInstr = 16'h0800;
          mPc    = 16'h0000;
          mErr   = 1'b0;
          mValid = 1'b0;
        end
        if (mValid && (mInstr[15:11] == 5'b00000)) mHalted = 1'b1;
      end
      if (countIt && mCnt < CNT_MAX) mCnt++;
    end
  end

  // Outputs are registered, so sampling on the falling edge sees settled values.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("model FD_instr", 32'(FD_instr), 32'(mInstr));
      checkOutput("model FD_pcPlus2", 32'(FD_pcPlus2), 32'(mPc));
      checkOutput("model FD_valid", 32'(FD_valid), 32'(mValid));
      checkOutput("model FD_err", 32'(FD_err), 32'(mErr));
      checkOutput("model FD_halted", 32'(FD_halted), 32'(mHalted));
      checkOutput("model fetch_hold", 32'(fetch_hold), 32'((skidQ.size() > 0) || mHalted));
      checkOutput("model stall_cnt", 32'(stall_cnt), 32'(mCnt));
    end
  end

  initial begin
    rst_n = 1'b0;
    F_valid = 1'b0; F_instr = '0; F_pcPlus2 = '0; F_err = 1'b0;
    stall_D = 1'b0; flush_D = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset FD_instr", 32'(FD_instr), 32'h0800);
    checkOutput("reset FD_valid", 32'(FD_valid), 32'h0);
    checkOutput("reset fetch_hold", 32'(fetch_hold), 32'h0);
    checkOutput("reset stall_cnt", 32'(stall_cnt), 32'h0);
    rst_n = 1'b1;

    // Plain load, one-cycle latency.
    applyStimulus(1'b1, 16'h4123, 16'h0002, 1'b0, 1'b0, 1'b0);
    checkOutput("load FD_instr", 32'(FD_instr), 32'h4123);
    checkOutput("load FD_pcPlus2", 32'(FD_pcPlus2), 32'h0002);
    checkOutput("load FD_valid", 32'(FD_valid), 32'h1);
    checkOutput("load fetch_hold", 32'(fetch_hold), 32'h0);

    // Stall three cycles; C0FF lands in the skid during the first.
    applyStimulus(1'b1, 16'h6104, 16'h0004, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hC0FF, 16'h0006, 1'b0, 1'b1, 1'b0);
    checkOutput("stall1 FD_instr", 32'(FD_instr), 32'h6104);
    checkOutput("stall1 fetch_hold", 32'(fetch_hold), 32'h1);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    checkOutput("stall3 FD_instr", 32'(FD_instr), 32'h6104);
    checkOutput("stall3 stall_cnt", 32'(stall_cnt), 32'h3);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    checkOutput("release FD_instr", 32'(FD_instr), 32'hC0FF);
    checkOutput("release FD_pcPlus2", 32'(FD_pcPlus2), 32'h0006);
    checkOutput("release fetch_hold", 32'(fetch_hold), 32'h0);

    // Flush with a full skid and stall asserted.
    applyStimulus(1'b1, 16'h7777, 16'h0008, 1'b0, 1'b1, 1'b0);
    checkOutput("skidfull fetch_hold", 32'(fetch_hold), 32'h1);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1);
    checkOutput("flush FD_instr", 32'(FD_instr), 32'h0800);
    checkOutput("flush FD_valid", 32'(FD_valid), 32'h0);
    checkOutput("flush fetch_hold", 32'(fetch_hold), 32'h0);
    checkOutput("flush stall_cnt", 32'(stall_cnt), 32'h4);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    checkOutput("bubble FD_valid", 32'(FD_valid), 32'h0);

    // HALT, ignored fetch while halted, flush out of HALTED.
    applyStimulus(1'b1, 16'h0000, 16'h000A, 1'b0, 1'b0, 1'b0);
    checkOutput("halt FD_halted", 32'(FD_halted), 32'h1);
    applyStimulus(1'b1, 16'h4123, 16'h000C, 1'b0, 1'b0, 1'b0);
    checkOutput("halted FD_instr", 32'(FD_instr), 32'h0000);
    checkOutput("halted FD_pcPlus2", 32'(FD_pcPlus2), 32'h000A);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    checkOutput("unhalt FD_halted", 32'(FD_halted), 32'h0);
    checkOutput("unhalt FD_instr", 32'(FD_instr), 32'h0800);

    // Fetch error carried through, then cleared by flush.
    applyStimulus(1'b1, 16'h9801, 16'h000E, 1'b1, 1'b0, 1'b0);
    checkOutput("err FD_err", 32'(FD_err), 32'h1);
    checkOutput("err FD_instr", 32'(FD_instr), 32'h9801);
    checkOutput("err FD_halted", 32'(FD_halted), 32'h0);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    checkOutput("errflush FD_err", 32'(FD_err), 32'h0);

    // HALT carrying an error still halts.
    applyStimulus(1'b1, 16'h0055, 16'h0012, 1'b1, 1'b0, 1'b0);
    checkOutput("errhalt FD_halted", 32'(FD_halted), 32'h1);
    checkOutput("errhalt FD_err", 32'(FD_err), 32'h1);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);

    // Counter saturation, then asynchronous reset in the middle of a stall.
    applyStimulus(1'b1, 16'h4123, 16'h0010, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    end
    checkOutput("sat stall_cnt", 32'(stall_cnt), 32'hF);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset FD_instr", 32'(FD_instr), 32'h0800);
    checkOutput("midreset FD_pcPlus2", 32'(FD_pcPlus2), 32'h0000);
    checkOutput("midreset FD_valid", 32'(FD_valid), 32'h0);
    checkOutput("midreset stall_cnt", 32'(stall_cnt), 32'h0);
    checkOutput("midreset fetch_hold", 32'(fetch_hold), 32'h0);
    @(negedge clk);
    stall_D = 1'b0;
    rst_n = 1'b1;
    applyStimulus(1'b1, 16'h1234, 16'h0020, 1'b0, 1'b0, 1'b0);
    checkOutput("postreset FD_instr", 32'(FD_instr), 32'h1234);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
